gpo_bank_ctrl: RTL

GPO_BANK_CTRL -- requirements
Module: gpo_bank_ctrl

---
 rtl/gpo_bank_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gpo_bank_ctrl.sv
// Bank of general-purpose output channels. Each channel has its own FSM that
// adds break-before-make dead time and a bias-supply check before it drives.
module gpo_bank_ctrl #(
  parameter int NCH       = 8,
  parameter int DEADTIME  = 4,
  parameter int BIAS_WAIT = 16,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               CFG_VALID_I,
  output logic               CFG_READY_O,
  input  logic [CHW-1:0]     CFG_CH_I,
  input  logic [1:0]         CFG_MODE_I,
  input  logic [1:0]         CFG_DS_I,
  input  logic               CFG_SR_I,
  input  logic [NCH-1:0]     DATA_I,
  input  logic               VBIAS_OK_I,
  input  logic [NCH-1:0]     ERR_CLR_I,
  output logic [NCH-1:0]     DO_O,
  output logic [NCH-1:0]     OE_O,
  output logic [NCH-1:0]     ODP_O,
  output logic [NCH-1:0]     ODN_O,
  output logic [NCH-1:0]     SR_O,
  output logic [2*NCH-1:0]   DS_O,
  output logic [NCH-1:0]     BUSY_O,
  output logic [NCH-1:0]     ERR_O
);

  localparam int CMAX = (DEADTIME > BIAS_WAIT) ? DEADTIME : BIAS_WAIT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_HIZ,
    S_DEAD,
    S_WAIT,
    S_ACTIVE
  } state_t;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CW-1:0]    cnt_q   [NCH];
  logic [CW-1:0]    cnt_d   [NCH];
  logic [1:0]       lmode_q [NCH];
  logic [1:0]       lmode_d [NCH];
  logic [1:0]       lds_q   [NCH];
  logic [1:0]       lds_d   [NCH];
  logic [NCH-1:0]   lsr_q, lsr_d;
  logic [NCH-1:0]   do_q;
  logic [NCH-1:0]   sr_q, sr_d;
  logic [NCH-1:0]   odp_q, odp_d;
  logic [NCH-1:0]   odn_q, odn_d;
  logic [NCH-1:0]   err_q, err_d;
  logic [2*NCH-1:0] ds_q, ds_d;
  logic [NCH-1:0]   err_set;
  logic [NCH-1:0]   hit;
  logic             ready;

  // Out-of-range channel numbers match no channel and are always ready.
  always_comb begin
    ready = 1'b1;
    hit   = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (CFG_CH_I == CHW'(n)) begin
        hit[n] = 1'b1;
        ready  = (state_q[n] == S_HIZ) || (state_q[n] == S_ACTIVE);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lmode_d = lmode_q;
    lds_d   = lds_q;
    lsr_d   = lsr_q;
    ds_d    = ds_q;
    sr_d    = sr_q;
    odp_d   = odp_q;
    odn_d   = odn_q;
    err_set = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      case (state_q[n])
        S_DEAD: begin
          if (cnt_q[n] == CW'(1)) begin
            // Pad controls switch only here, while OE is still low.
            ds_d[2*n +: 2] = lds_q[n];
            sr_d[n]        = lsr_q[n];
            odp_d[n]       = (lmode_q[n] == 2'b10);
            odn_d[n]       = (lmode_q[n] == 2'b11);
            if ((lds_q[n] == 2'b00) || VBIAS_OK_I) begin
              state_d[n] = S_ACTIVE;
              cnt_d[n]   = '0;
            end else begin
              state_d[n] = S_WAIT;
              cnt_d[n]   = CW'(BIAS_WAIT);
            end
          end else begin
            cnt_d[n] = cnt_q[n] - 1'b1;
          end
        end
        S_WAIT: begin
          if (VBIAS_OK_I) begin
            state_d[n] = S_ACTIVE;
            cnt_d[n]   = '0;
          end else if (cnt_q[n] == CW'(1)) begin
            state_d[n] = S_HIZ;
            cnt_d[n]   = '0;
            err_set[n] = 1'b1;
          end else begin
            cnt_d[n] = cnt_q[n] - 1'b1;
          end
        end
        S_ACTIVE: begin
          if ((ds_q[2*n +: 2] != 2'b00) && !VBIAS_OK_I) begin
            state_d[n] = S_HIZ;
            err_set[n] = 1'b1;
          end
        end
        default: ;
      endcase

      if (CFG_VALID_I && ready && hit[n]) begin
        if (CFG_MODE_I == 2'b00) begin
          state_d[n] = S_HIZ;
          cnt_d[n]   = '0;
        end else begin
          lmode_d[n] = CFG_MODE_I;
          lds_d[n]   = CFG_DS_I;
          lsr_d[n]   = CFG_SR_I;
          state_d[n] = S_DEAD;
          cnt_d[n]   = CW'(DEADTIME);
        end
      end
    end
    err_d = (err_q & ~ERR_CLR_I) | err_set;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        state_q[n] <= S_HIZ;
        cnt_q[n]   <= '0;
        lmode_q[n] <= '0;
        lds_q[n]   <= '0;
      end
      lsr_q <= '0;
      do_q  <= '0;
      sr_q  <= '0;
      odp_q <= '0;
      odn_q <= '0;
      err_q <= '0;
      ds_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lmode_q <= lmode_d;
      lds_q   <= lds_d;
      lsr_q   <= lsr_d;
      do_q    <= DATA_I;
      sr_q    <= sr_d;
      odp_q   <= odp_d;
      odn_q   <= odn_d;
      err_q   <= err_d;
      ds_q    <= ds_d;
    end
  end

  always_comb begin
    OE_O   = '0;
    BUSY_O = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      OE_O[n]   = (state_q[n] == S_ACTIVE);
      BUSY_O[n] = (state_q[n] == S_DEAD) || (state_q[n] == S_WAIT);
    end
  end

  assign CFG_READY_O = ready;
  assign DO_O        = do_q;
  assign SR_O        = sr_q;
  assign ODP_O       = odp_q;
  assign ODN_O       = odn_q;
  assign DS_O        = ds_q;
  assign ERR_O       = err_q;

endmodule
